sprite_rle_loader: RTL and testbench

Run-length-decoding writer that fills the sprite, map and collision RAMs through their write ports (`we`, `write_address`, `data_In`) from a byte stream, e.g. a UART or flash reader. It sits between the stream source and one RAM instance, opposite the VGA read path. Once loaded, the RAM contents can be replaced at run time without rebuilding the `$readmemh` images.

---
 rtl/sprite_rle_loader.sv | 138 +++++++++++++
 tb/tb_sprite_rle_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sprite_rle_loader.sv
// Run-length decoder that turns a (run, value) byte stream into sequential RAM writes.
// Every output is a register loaded from next-state values, so no output depends combinationally on an input.
module sprite_rle_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 19
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              we,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] data_In,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [2:0] {S_IDLE, S_GET_RUN, S_GET_VAL, S_WRITE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] offset_q, offset_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  logic [8:0]        run_q, run_d;
  logic [DATA_W-1:0] value_q, value_d;
  logic              ovf_d;
  logic              xfer;
  logic              issue;
  logic [DATA_W-1:0] issue_data;
  logic              in_ready_d, we_d, busy_d, done_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d;

  assign xfer = in_valid && in_ready;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= S_IDLE;
      base_q        <= '0;
      offset_q      <= '0;
      remain_q      <= '0;
      run_q         <= '0;
      value_q       <= '0;
      in_ready      <= 1'b0;
      we            <= 1'b0;
      write_address <= '0;
      data_In       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      offset_q      <= offset_d;
      remain_q      <= remain_d;
      run_q         <= run_d;
      value_q       <= value_d;
      in_ready      <= in_ready_d;
      we            <= we_d;
      write_address <= addr_d;
      data_In       <= data_d;
      busy          <= busy_d;
      done          <= done_d;
      overflow      <= ovf_d;
    end
  end

  // Counters track words issued, one cycle ahead of the registered write port.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    offset_d   = offset_q;
    remain_d   = remain_q;
    run_d      = run_q;
    value_d    = value_q;
    ovf_d      = overflow;
    issue      = 1'b0;
    issue_data = value_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          remain_d = length;
          offset_d = '0;
          ovf_d    = 1'b0;
          state_d  = (length == '0) ? S_DONE : S_GET_RUN;
        end
      end
      S_GET_RUN: begin
        if (xfer) begin
          run_d   = {1'b0, in_data} + 9'd1;
          state_d = S_GET_VAL;
        end
      end
      S_GET_VAL: begin
        if (xfer) begin
          value_d    = in_data[DATA_W-1:0];
          issue_data = in_data[DATA_W-1:0];
          issue      = 1'b1;
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        // Words left in the run when the load quota is used up mean the stream overran length.
        if (remain_q == '0) begin
          ovf_d   = (run_q != 9'd0);
          state_d = S_DONE;
        end else if (run_q == 9'd0) begin
          state_d = S_GET_RUN;
        end else begin
          issue = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (issue) begin
      offset_d = offset_q + ADDR_W'(1);
      run_d    = run_q - 9'd1;
      remain_d = remain_q - ADDR_W'(1);
    end
  end

  always_comb begin
    in_ready_d = (state_d == S_GET_RUN) || (state_d == S_GET_VAL);
    busy_d     = (state_d == S_GET_RUN) || (state_d == S_GET_VAL) || (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
    we_d       = issue;
    addr_d     = issue ? (base_q + offset_q) : write_address;
    data_d     = issue ? issue_data : data_In;
  end

endmodule

// File: tb/tb_sprite_rle_loader.sv
// Randomised bench: a token-level reference model predicts the write list, overflow,
// bytes consumed and done latency for two loader instances (8/19-bit and 4/4-bit).
module tb_sprite_rle_loader;

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset, start1, start2, in_valid, sel;
  logic [7:0]  in_data;
  logic [18:0] base_addr, length;

  logic        rdy1, we1, busy1, done1, ovf1;
  logic [18:0] wa1;
  logic [7:0]  di1;
  logic        rdy2, we2, busy2, done2, ovf2;
  logic [3:0]  wa2, di2;

  sprite_rle_loader dut1 (
    .Clk(Clk), .Reset(Reset), .start(start1), .base_addr(base_addr), .length(length),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1), .we(we1),
    .write_address(wa1), .data_In(di1), .busy(busy1), .done(done1), .overflow(ovf1)
  );

  sprite_rle_loader #(.DATA_W(4), .ADDR_W(4)) dut2 (
    .Clk(Clk), .Reset(Reset), .start(start2), .base_addr(base_addr[3:0]), .length(length[3:0]),
    .in_data(in_data), .in_valid(in_valid), .in_ready(rdy2), .we(we2),
    .write_address(wa2), .data_In(di2), .busy(busy2), .done(done2), .overflow(ovf2)
  );

  logic        rdy_m, we_m, busy_m, done_m, ovf_m;
  logic [18:0] wa_m;
  logic [7:0]  di_m;
  assign rdy_m  = sel ? rdy2  : rdy1;
  assign we_m   = sel ? we2   : we1;
  assign busy_m = sel ? busy2 : busy1;
  assign done_m = sel ? done2 : done1;
  assign ovf_m  = sel ? ovf2  : ovf1;
  assign wa_m   = sel ? {15'd0, wa2} : wa1;
  assign di_m   = sel ? {4'd0, di2}  : di1;

  int          n_vec = 0;
  int          n_miss = 0;
  int unsigned cyc = 0;
  logic [7:0]  stream_q[$];

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic gen_stream(input int len, input int maxrun);
    int total = 0;
    stream_q.delete();
    while (total < len) begin
      int r = $urandom_range(maxrun);
      stream_q.push_back(8'(r));
      stream_q.push_back(8'($urandom_range(255)));
      total += r + 1;
    end
    stream_q.push_back(8'($urandom_range(maxrun)));
    stream_q.push_back(8'($urandom_range(255)));
  endtask

  task automatic do_load(input string name, input bit s, input logic [18:0] base,
                         input logic [18:0] len, input bit gaps, input bit bstart);
    logic [18:0] ea[$];
    logic [7:0]  ed[$];
    logic [18:0] amask = s ? 19'h0000F : 19'h7FFFF;
    logic [7:0]  dmask = s ? 8'h0F : 8'hFF;
    int rem = int'(len), off = 0, i = 0, n, w, exp_cyc = 0;
    bit exp_ovf = 1'b0, hold = 1'b0;
    int idx = 0, got = 0, done_cnt = 0, dk = -1;
    int unsigned t0, dcyc = 0;

    // Reference: walk whole tokens until the word quota is used up.
    while (rem > 0 && i + 1 < stream_q.size()) begin
      n = int'(stream_q[i]) + 1;
      w = (n < rem) ? n : rem;
      for (int k = 0; k < w; k++) begin
        ea.push_back((base + 19'(off)) & amask);
        ed.push_back(stream_q[i+1] & dmask);
        off++;
      end
      rem -= w;
      exp_ovf = (n > w);
      exp_cyc += 2 + w;
      i += 2;
    end

    sel = s;
    @(negedge Clk);
    base_addr = base;
    length    = len;
    in_valid  = 1'b0;
    if (s) start2 = 1'b1; else start1 = 1'b1;
    @(negedge Clk);
    t0 = cyc;
    start1 = 1'b0;
    start2 = 1'b0;
    check_eq({name, " busy@T+1"}, busy_m, len != 0);
    check_eq({name, " ready@T+1"}, rdy_m, len != 0);

    for (int k = 0; k < 3000; k++) begin
      if (k > 0) @(negedge Clk);
      if (we_m) begin
        if (got < ea.size()) begin
          check_eq({name, " addr"}, wa_m, ea[got]);
          check_eq({name, " data"}, di_m, ed[got]);
        end else begin
          check_eq({name, " write_count"}, got + 1, ea.size());
        end
        got++;
      end
      if (done_m) begin
        done_cnt++;
        if (dk < 0) begin
          dk = k;
          dcyc = cyc - t0;
        end
      end
      start1 = !s && bstart && k == 2 && busy_m;
      start2 =  s && bstart && k == 2 && busy_m;
      if (!hold) begin
        if (idx < stream_q.size() && (!gaps || $urandom_range(2) != 0)) begin
          in_valid = 1'b1;
          in_data  = stream_q[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (in_valid && rdy_m) begin
        idx++;
        hold = 1'b0;
      end else begin
        hold = in_valid;
      end
      if (dk >= 0 && k >= dk + 6) break;
    end
    in_valid = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;

    check_eq({name, " done_count"}, done_cnt, 1);
    check_eq({name, " write_count"}, got, ea.size());
    check_eq({name, " overflow"}, ovf_m, exp_ovf);
    check_eq({name, " bytes_taken"}, idx, i);
    if (!gaps && dk >= 0) check_eq({name, " done_latency"}, dcyc, exp_cyc);
    $display("load %s dut%0d base=0x%0h len=%0d writes=%0d/%0d ovf=%0b gaps=%0b",
             name, s + 1, base, len, got, ea.size(), ovf_m, gaps);
  endtask

  initial begin
    int wcnt;
    Reset = 1'b1; start1 = 1'b0; start2 = 1'b0; sel = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; base_addr = '0; length = '0;
    repeat (3) @(negedge Clk);
    check_eq("reset dut1", {rdy1, we1, busy1, done1, ovf1, wa1, di1}, 32'd0);
    check_eq("reset dut2", {rdy2, we2, busy2, done2, ovf2, wa2, di2}, 32'd0);
    Reset = 1'b0;

    stream_q = '{8'h02, 8'hA7, 8'h01, 8'h3C, 8'h00, 8'h99};
    do_load("basic", 1'b0, 19'h100, 19'd5, 1'b0, 1'b0);
    stream_q = '{8'h04, 8'h11, 8'h07, 8'h22};
    do_load("overflow", 1'b0, 19'h200, 19'd3, 1'b0, 1'b0);
    stream_q = '{8'h03, 8'hF5, 8'h00, 8'h00};
    do_load("wrap4", 1'b1, 19'hE, 19'd4, 1'b0, 1'b0);
    stream_q = '{8'h05, 8'h3C, 8'h01, 8'h02};
    do_load("wrap19", 1'b0, 19'h7FFFE, 19'd4, 1'b0, 1'b0);
    stream_q = '{8'h02, 8'hA7, 8'h01, 8'h3C, 8'h00, 8'h99};
    do_load("backpressure", 1'b0, 19'h100, 19'd5, 1'b1, 1'b1);
    stream_q = '{8'h01, 8'h02};
    do_load("len0", 1'b0, 19'h123, 19'd0, 1'b0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      bit s = 1'($urandom_range(1));
      int len = s ? $urandom_range(15) : $urandom_range(60);
      gen_stream(len, (t % 3 == 0) ? 40 : 12);
      do_load($sformatf("rand%0d", t), s, 19'($urandom), 19'(len),
              1'($urandom_range(1)), 1'($urandom_range(1)));
    end

    // Reset in the middle of a write run; no further writes may follow.
    sel = 1'b0;
    @(negedge Clk);
    base_addr = 19'h40; length = 19'd20; start1 = 1'b1;
    @(negedge Clk);
    start1 = 1'b0; in_valid = 1'b1; in_data = 8'h09;
    wcnt = 0;
    for (int k = 0; k < 20 && wcnt < 2; k++) begin
      @(negedge Clk);
      if (we1) wcnt++;
    end
    check_eq("rst pre_we", wcnt, 2);
    Reset = 1'b1;
    @(negedge Clk);
    check_eq("rst we", we1, 1'b0);
    check_eq("rst busy", busy1, 1'b0);
    check_eq("rst ready", rdy1, 1'b0);
    Reset = 1'b0;
    wcnt = 0;
    repeat (6) begin
      @(negedge Clk);
      if (we1) wcnt++;
    end
    in_valid = 1'b0;
    check_eq("rst no_we", wcnt, 0);
    $display("load reset_mid_run dut1 writes_after_reset=%0d", wcnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
